vreg_req_issuer: RTL and testbench

Per-lane request issuer that sits directly upstream of the lane-to-vector-register crossbar, one instance per crossbar port. It buffers lane read/write requests in a small FIFO and presents one request at a time to its crossbar port. It retries until the crossbar's registered `rsp_vld` confirms the grant, then returns read data or a write acknowledgement to the lane. It also flags head-of-line starvation when arbitration keeps losing.

---
 rtl/vreg_req_issuer.sv | 165 ++++++++++++++++
 tb/tb_vreg_req_issuer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vreg_req_issuer.sv
// Per-lane request issuer: FIFOs lane requests and issues them one at a time to a crossbar port.
// Optional head-of-line starvation counter enabled by defining VREG_ISSUER_STARVE_CNT_EN.
module vreg_req_issuer #(
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned ADDR_W    = 6,
   parameter int unsigned DATA_W    = 64,
   parameter int unsigned PTR_W     = 5,
   parameter int unsigned MAX_RETRY = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enq_vld,
   output logic              enq_ready,
   input  logic              enq_is_write,
   input  logic [PTR_W-1:0]  enq_ptr,
   input  logic [ADDR_W-1:0] enq_addr,
   input  logic [DATA_W-1:0] enq_data,
   output logic              req_vld,
   output logic              req_is_write,
   output logic [PTR_W-1:0]  req_ptr,
   output logic [ADDR_W-1:0] req_addr,
   output logic [DATA_W-1:0] req_data,
   input  logic              rsp_vld,
   input  logic [DATA_W-1:0] vreg_rd_data,
   output logic              lane_rsp_vld,
   output logic              lane_rsp_is_write,
   output logic [DATA_W-1:0] lane_rsp_data,
   output logic              starve_err
);

   localparam int unsigned IdxW = $clog2(DEPTH);
   localparam int unsigned CntW = IdxW + 1;

   typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   count_q, count_d;
   logic [IdxW-1:0]   wr_idx_q, wr_idx_d;
   logic [IdxW-1:0]   rd_idx_q, rd_idx_d;
   logic              mem_wr_q   [DEPTH];
   logic [PTR_W-1:0]  mem_ptr_q  [DEPTH];
   logic [ADDR_W-1:0] mem_addr_q [DEPTH];
   logic [DATA_W-1:0] mem_data_q [DEPTH];
   logic              lane_rsp_vld_q, lane_rsp_is_write_q;
   logic [DATA_W-1:0] lane_rsp_data_q;
   logic              push, pop, head_vld;

   assign enq_ready = (count_q != CntW'(DEPTH));
   assign push      = enq_vld && enq_ready;
   assign pop       = (state_q == StWait) && rsp_vld;
   assign head_vld  = (count_q != '0);

   always_comb begin
      count_d  = count_q + CntW'(push) - CntW'(pop);
      wr_idx_d = wr_idx_q + IdxW'(push);
      rd_idx_d = rd_idx_q + IdxW'(pop);
   end

   // req_vld is dropped in WAIT so a single entry can never collect two grants
   always_comb begin
      state_d = state_q;
      req_vld = 1'b0;
      unique case (state_q)
         StIdle:  if (head_vld) state_d = StIssue;
         StIssue: begin
            req_vld = 1'b1;
            state_d = StWait;
         end
         StWait: begin
            if (rsp_vld) state_d = (count_d != '0) ? StIssue : StIdle;
            else         state_d = StIssue;
         end
         default: state_d = StIdle;
      endcase
   end

   assign req_is_write = head_vld ? mem_wr_q[rd_idx_q]   : 1'b0;
   assign req_ptr      = head_vld ? mem_ptr_q[rd_idx_q]  : '0;
   assign req_addr     = head_vld ? mem_addr_q[rd_idx_q] : '0;
   assign req_data     = head_vld ? mem_data_q[rd_idx_q] : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         count_q  <= '0;
         wr_idx_q <= '0;
         rd_idx_q <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         wr_idx_q <= wr_idx_d;
         rd_idx_q <= rd_idx_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_wr_q[i]   <= 1'b0;
            mem_ptr_q[i]  <= '0;
            mem_addr_q[i] <= '0;
            mem_data_q[i] <= '0;
         end
      end else if (push) begin
         mem_wr_q[wr_idx_q]   <= enq_is_write;
         mem_ptr_q[wr_idx_q]  <= enq_ptr;
         mem_addr_q[wr_idx_q] <= enq_addr;
         mem_data_q[wr_idx_q] <= enq_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lane_rsp_vld_q      <= 1'b0;
         lane_rsp_is_write_q <= 1'b0;
         lane_rsp_data_q     <= '0;
      end else begin
         lane_rsp_vld_q <= pop;
         if (pop) begin
            lane_rsp_is_write_q <= mem_wr_q[rd_idx_q];
            lane_rsp_data_q     <= mem_wr_q[rd_idx_q] ? '0 : vreg_rd_data;
         end
      end
   end

   assign lane_rsp_vld      = lane_rsp_vld_q;
   assign lane_rsp_is_write = lane_rsp_is_write_q;
   assign lane_rsp_data     = lane_rsp_data_q;

`ifdef VREG_ISSUER_STARVE_CNT_EN
   localparam int unsigned RetryW = $clog2(MAX_RETRY + 1);

   logic [RetryW-1:0] retry_q, retry_d;
   logic              starve_q, starve_d;

   // Counter saturates; the flag is sticky until reset
   always_comb begin
      retry_d  = retry_q;
      starve_d = starve_q;
      if (state_q == StWait) begin
         if (rsp_vld) begin
            retry_d = '0;
         end else if (retry_q != RetryW'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            if (retry_q == RetryW'(MAX_RETRY - 1)) starve_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         retry_q  <= '0;
         starve_q <= 1'b0;
      end else begin
         retry_q  <= retry_d;
         starve_q <= starve_d;
      end
   end

   assign starve_err = starve_q;
`else
   assign starve_err = 1'b0;
`endif

endmodule

// File: tb/tb_vreg_req_issuer.sv
// Directed, table-driven bench for vreg_req_issuer (default parameters).
module tb_vreg_req_issuer;

   logic        clk, reset;
   logic        enq_vld, enq_ready, enq_is_write;
   logic [4:0]  enq_ptr;
   logic [5:0]  enq_addr;
   logic [63:0] enq_data;
   logic        req_vld, req_is_write;
   logic [4:0]  req_ptr;
   logic [5:0]  req_addr;
   logic [63:0] req_data;
   logic        rsp_vld;
   logic [63:0] vreg_rd_data;
   logic        lane_rsp_vld, lane_rsp_is_write;
   logic [63:0] lane_rsp_data;
   logic        starve_err;

`ifdef VREG_ISSUER_STARVE_CNT_EN
   localparam logic ExpStarve = 1'b1;
`else
   localparam logic ExpStarve = 1'b0;
`endif

   typedef struct {
      logic        wr;
      logic [4:0]  ptr;
      logic [5:0]  addr;
      logic [63:0] wdata;
      logic [63:0] rdata;
      logic [63:0] exp_data;
   } vec_t;

   vec_t vecs [20];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   req_cnt  = 0;
   int   lane_cnt = 0;
   int   req_base, lane_base;

   vreg_req_issuer dut (
      .clk               (clk),
      .reset             (reset),
      .enq_vld           (enq_vld),
      .enq_ready         (enq_ready),
      .enq_is_write      (enq_is_write),
      .enq_ptr           (enq_ptr),
      .enq_addr          (enq_addr),
      .enq_data          (enq_data),
      .req_vld           (req_vld),
      .req_is_write      (req_is_write),
      .req_ptr           (req_ptr),
      .req_addr          (req_addr),
      .req_data          (req_data),
      .rsp_vld           (rsp_vld),
      .vreg_rd_data      (vreg_rd_data),
      .lane_rsp_vld      (lane_rsp_vld),
      .lane_rsp_is_write (lane_rsp_is_write),
      .lane_rsp_data     (lane_rsp_data),
      .starve_err        (starve_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (req_vld)      req_cnt  <= req_cnt + 1;
      if (lane_rsp_vld) lane_cnt <= lane_cnt + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic enq(input logic wr, input logic [4:0] ptr, input logic [5:0] addr,
                      input logic [63:0] data);
      enq_vld      = 1'b1;
      enq_is_write = wr;
      enq_ptr      = ptr;
      enq_addr     = addr;
      enq_data     = data;
      tick();
      enq_vld = 1'b0;
   endtask

   task automatic wait_req(input string nm);
      int n = 0;
      while (!req_vld && n < 20) begin
         tick();
         n++;
      end
      chk({nm, "/req_vld_seen"}, req_vld, 1'b1);
   endtask

   // Serve the head entry: 'fails' lost arbitrations, then a grant
   task automatic serve(input string nm, input logic wr, input logic [4:0] ptr,
                        input logic [5:0] addr, input logic [63:0] wdata, input int fails,
                        input logic [63:0] rdata, input logic [63:0] exp_data);
      for (int a = 0; a <= fails; a++) begin
         wait_req(nm);
         chk({nm, "/req_ptr"}, req_ptr, ptr);
         chk({nm, "/req_addr"}, req_addr, addr);
         chk({nm, "/req_is_write"}, req_is_write, wr);
         chk({nm, "/req_data"}, req_data, wdata);
         tick();
         chk({nm, "/req_vld_wait"}, req_vld, 1'b0);
         rsp_vld      = (a == fails);
         vreg_rd_data = rdata;
         tick();
         rsp_vld      = 1'b0;
         vreg_rd_data = '0;
      end
      chk({nm, "/lane_rsp_vld"}, lane_rsp_vld, 1'b1);
      chk({nm, "/lane_rsp_is_write"}, lane_rsp_is_write, wr);
      chk({nm, "/lane_rsp_data"}, lane_rsp_data, exp_data);
   endtask

   task automatic do_reset;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 10; i++) begin
         vecs[2*i].wr       = 1'b1;
         vecs[2*i].ptr      = 5'(i);
         vecs[2*i].addr     = 6'(i * 3 + 1);
         vecs[2*i].wdata    = 64'h0123_4567_0000_0000 + 64'(i) * 64'h1111;
         vecs[2*i].rdata    = 64'hBAD0 + 64'(i);
         vecs[2*i].exp_data = 64'h0;
         vecs[2*i+1].wr       = 1'b0;
         vecs[2*i+1].ptr      = 5'(i);
         vecs[2*i+1].addr     = 6'(i * 3 + 1);
         vecs[2*i+1].wdata    = 64'h0;
         vecs[2*i+1].rdata    = vecs[2*i].wdata;
         vecs[2*i+1].exp_data = vecs[2*i].wdata;
      end

      reset = 1'b1; enq_vld = 1'b0; enq_is_write = 1'b0; enq_ptr = '0; enq_addr = '0;
      enq_data = '0; rsp_vld = 1'b0; vreg_rd_data = '0;
      tick();
      chk("rst/enq_ready", enq_ready, 1'b1);
      chk("rst/req_vld", req_vld, 1'b0);
      chk("rst/req_ptr", req_ptr, 5'd0);
      chk("rst/req_addr", req_addr, 6'd0);
      chk("rst/req_data", req_data, 64'd0);
      chk("rst/lane_rsp_vld", lane_rsp_vld, 1'b0);
      chk("rst/lane_rsp_data", lane_rsp_data, 64'd0);
      chk("rst/starve_err", starve_err, 1'b0);
      tick();
      reset = 1'b0;
      tick();

      // Single read with exact latency
      enq_vld = 1'b1; enq_is_write = 1'b0; enq_ptr = 5'd3; enq_addr = 6'd5; enq_data = '0;
      tick();
      enq_vld = 1'b0;
      chk("single/T1_req_vld", req_vld, 1'b0);
      chk("single/T1_req_ptr", req_ptr, 5'd3);
      tick();
      chk("single/T2_req_vld", req_vld, 1'b1);
      chk("single/T2_req_ptr", req_ptr, 5'd3);
      chk("single/T2_req_addr", req_addr, 6'd5);
      tick();
      chk("single/T3_req_vld", req_vld, 1'b0);
      rsp_vld = 1'b1; vreg_rd_data = 64'hDEAD;
      tick();
      rsp_vld = 1'b0; vreg_rd_data = '0;
      chk("single/T4_lane_vld", lane_rsp_vld, 1'b1);
      chk("single/T4_lane_data", lane_rsp_data, 64'hDEAD);
      chk("single/T4_lane_wr", lane_rsp_is_write, 1'b0);
      tick();
      chk("single/T5_lane_vld", lane_rsp_vld, 1'b0);
      chk("single/T5_req_vld", req_vld, 1'b0);
      chk("single/T5_req_ptr", req_ptr, 5'd0);

      // Fill: 5 back-to-back enqueues, no grants
      for (int k = 0; k < 5; k++) begin
         enq_vld = 1'b1; enq_is_write = 1'b0; enq_ptr = 5'(10 + k); enq_addr = 6'(k);
         enq_data = 64'(k);
         chk("fill/enq_ready", enq_ready, (k < 4) ? 1'b1 : 1'b0);
         tick();
      end
      enq_vld = 1'b0;
      chk("fill/enq_ready_full", enq_ready, 1'b0);
      for (int k = 0; k < 6; k++) begin
         chk("fill/head_held", req_ptr, 5'd10);
         tick();
      end
      for (int k = 0; k < 4; k++)
         serve("fill/drain", 1'b0, 5'(10 + k), 6'(k), 64'(k), 0, 64'hF000 + 64'(k),
               64'hF000 + 64'(k));
      tick(); tick(); tick();
      chk("fill/empty_req_vld", req_vld, 1'b0);
      chk("fill/empty_req_ptr", req_ptr, 5'd0);
      chk("fill/empty_enq_ready", enq_ready, 1'b1);

      // Retry: 3 lost arbitrations, then a following write
      req_base  = req_cnt;
      lane_base = lane_cnt;
      enq(1'b0, 5'd7, 6'd9, 64'h0);
      enq(1'b1, 5'd8, 6'd1, 64'hCAFE);
      serve("retry/rd", 1'b0, 5'd7, 6'd9, 64'h0, 3, 64'h1234, 64'h1234);
      chk("retry/req_pulses_first", 64'(req_cnt - req_base), 64'd4);
      serve("retry/wr", 1'b1, 5'd8, 6'd1, 64'hCAFE, 0, 64'hBAD, 64'h0);
      tick(); tick(); tick();
      chk("retry/req_pulses_total", 64'(req_cnt - req_base), 64'd5);
      chk("retry/lane_pulses", 64'(lane_cnt - lane_base), 64'd2);

      // Starvation: 15 failed WAITs, then a grant
      enq(1'b0, 5'd2, 6'd2, 64'h0);
      for (int k = 1; k <= 15; k++) begin
         wait_req("starve");
         tick();
         tick();
         if (k == 14) chk("starve/before_limit", starve_err, 1'b0);
      end
      chk("starve/at_limit", starve_err, ExpStarve);
      serve("starve/grant", 1'b0, 5'd2, 6'd2, 64'h0, 0, 64'h55, 64'h55);
      tick();
      chk("starve/sticky", starve_err, ExpStarve);

      // Reset while a request is in WAIT with 2 entries queued
      enq(1'b0, 5'd4, 6'd4, 64'h0);
      enq(1'b1, 5'd5, 6'd5, 64'h77);
      wait_req("rstwait");
      tick();
      req_base  = req_cnt;
      lane_base = lane_cnt;
      #2 reset = 1'b1;
      #1;
      chk("rstwait/enq_ready", enq_ready, 1'b1);
      chk("rstwait/req_vld", req_vld, 1'b0);
      chk("rstwait/req_ptr", req_ptr, 5'd0);
      chk("rstwait/req_data", req_data, 64'd0);
      chk("rstwait/lane_rsp_vld", lane_rsp_vld, 1'b0);
      chk("rstwait/starve_err", starve_err, 1'b0);
      tick();
      tick();
      reset = 1'b0;
      rsp_vld = 1'b1; vreg_rd_data = 64'h99;
      tick(); tick(); tick();
      rsp_vld = 1'b0; vreg_rd_data = '0;
      tick();
      chk("rstwait/no_req", 64'(req_cnt - req_base), 64'd0);
      chk("rstwait/no_lane_rsp", 64'(lane_cnt - lane_base), 64'd0);
      chk("rstwait/lane_data", lane_rsp_data, 64'd0);
      chk("rstwait/enq_ready_after", enq_ready, 1'b1);

      // Pointer wrap: 10 write/read pairs
      do_reset();
      for (int i = 0; i < 20; i++) begin
         enq(vecs[i].wr, vecs[i].ptr, vecs[i].addr, vecs[i].wdata);
         serve($sformatf("wrap[%0d]", i), vecs[i].wr, vecs[i].ptr, vecs[i].addr,
               vecs[i].wdata, 0, vecs[i].rdata, vecs[i].exp_data);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
